// File: rtl/mac_pkg.sv
// Shared MAC datapath package.
// Holds the controller state encoding and the width constants that the
// multiplier and the downstream MAC blocks agree on.
package mac_pkg;

    // Accumulator controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_t;

    localparam int PROD_W    = 64;  // multiplier product width
    localparam int ACC_W_DEF = 72;  // default accumulator width
    localparam int LEN_W_DEF = 16;  // default beat-count width

endpackage : mac_pkg

// File: rtl/mac_accumulator_64.sv
// mult_accumulator_64
// Sums a programmed number of 64-bit unsigned products into an ACC_W-bit
// accumulator and returns the sum with a sticky overflow flag.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, len          job request / product count (sampled when start_ready)
//   start_ready         high in IDLE
//   prod_valid/ready    product stream handshake (ready high in ACCUM)
//   prod_data           64-bit unsigned product
//   res_valid/ready     result handshake (valid high in DONE)
//   res_data, res_ovf   accumulated sum and carry-out-of-MSB flag
//   busy                high whenever not IDLE
module mult_accumulator_64
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    output logic               start_ready,
    input  logic               prod_valid,
    input  logic [PROD_W-1:0]  prod_data,
    output logic               prod_ready,
    output logic               res_valid,
    output logic [ACC_W-1:0]   res_data,
    output logic               res_ovf,
    input  logic               res_ready,
    output logic               busy
);

    mac_state_t          state_r;
    mac_state_t          state_nxt_s;
    logic [ACC_W-1:0]    acc_r;
    logic                ovf_r;
    logic [LEN_W-1:0]    cnt_r;
    logic [ACC_W:0]      sum_s;
    logic                beat_s;

    // One extra bit on the adder: its MSB is the carry folded into ovf_r.
    assign sum_s  = {1'b0, acc_r} + {{(ACC_W - PROD_W + 1){1'b0}}, prod_data};
    assign beat_s = (state_r == ACCUM) && prod_valid;

    // Handshake outputs decode state only; result fields come straight from registers.
    assign start_ready = (state_r == IDLE);
    assign prod_ready  = (state_r == ACCUM);
    assign res_valid   = (state_r == DONE);
    assign busy        = (state_r != IDLE);
    assign res_data    = acc_r;
    assign res_ovf     = ovf_r;

    // Next-state logic for job sequencing.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len == LEN_W'(0)) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (beat_s && (cnt_r == LEN_W'(1))) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, accumulator, overflow flag and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= ACC_W'(0);
            ovf_r   <= 1'b0;
            cnt_r   <= LEN_W'(0);
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r <= ACC_W'(0);
                        ovf_r <= 1'b0;
                        cnt_r <= len;
                    end
                end
                ACCUM: begin
                    if (beat_s) begin
                        acc_r <= sum_s[ACC_W-1:0];
                        ovf_r <= ovf_r | sum_s[ACC_W];
                        cnt_r <= cnt_r - LEN_W'(1);
                    end
                end
                DONE: begin
                    // acc_r/ovf_r stay valid until the next job starts.
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule : mult_accumulator_64

// File: doc/mult_accumulator_64.md
# mult_accumulator_64

Downstream consumer of the 32×32 unsigned multiplier's 64-bit product stream. It sums a programmed number of products into a wide accumulator, forming a dot product, and returns the sum through a valid/ready result port. It sits directly after the multiplier in the MAC datapath. It owns job sequencing, beat counting and overflow flagging; the multiplier remains purely combinational upstream.

## Interface
Parameters:
- ACC_W, 72, accumulator/result width; must be ≥ 64.
- LEN_W, 16, width of the beat-count field.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  job request; accepted only when start_ready=1.
- len  input  LEN_W  number of products in the job; sampled on start acceptance.
- start_ready  output  1  high only in IDLE.
- prod_valid  input  1  upstream product valid.
- prod_data  input  64  unsigned product from the multiplier.
- prod_ready  output  1  high only in ACCUM.
- res_valid  output  1  result available; high only in DONE.
- res_data  output  ACC_W  accumulated sum.
- res_ovf  output  1  sticky flag: carry out of bit ACC_W-1 occurred during the job.
- res_ready  input  1  downstream accepts result.
- busy  output  1  high when state ≠ IDLE.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start_ready=1.
  - On start: acc←0, ovf←0, cnt←len.
  - If len==0, go to DONE; otherwise go to ACCUM.
- ACCUM:
  - prod_ready=1.
  - A beat is a cycle with prod_valid&prod_ready. Per beat: acc←(acc + zero-extended prod_data) mod 2^ACC_W; ovf←ovf | carry-out; cnt←cnt−1.
  - The beat with cnt==1 is the last; the next state is DONE.
  - No beat when prod_valid=0; state and registers hold.
- DONE:
  - res_valid=1; res_data=acc, res_ovf=ovf, both held stable.
  - On res_ready: go to IDLE. acc and ovf keep their values; they are cleared only on the next start.
- start is ignored outside IDLE and is not queued.
- prod_valid is ignored outside ACCUM; no product is consumed.
- Arithmetic is unsigned throughout. Wrap-around is modulo 2^ACC_W, and overflow is reported through res_ovf.
- A job may contain at most 2^LEN_W−1 products.

## Timing
- Reset values: start_ready=1, prod_ready=0, res_valid=0, res_data=0, res_ovf=0, busy=0; state IDLE; cnt=0.
- rst wins over every other input in the same cycle. Reset mid-job discards the job: the next cycle shows the reset values, and no result is emitted.
- Start acceptance at edge N: busy=1 and prod_ready=1 from cycle N+1. For len==0, res_valid=1 from cycle N+1 instead.
- Last beat accepted at edge M: res_valid=1 and final res_data visible in cycle M+1. prod_ready=0 in that same cycle.
- Result handshake at edge R: res_valid=0 and start_ready=1 in cycle R+1. The earliest next start is at edge R+1.
- Throughput: one product per cycle while prod_valid is held high. Job overhead is 2 cycles: the start cycle and the result cycle.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

## Structure
- Shared package mac_pkg:
  - state enum mac_state_t {IDLE, ACCUM, DONE}.
  - Constants PROD_W=64, ACC_W_DEF=72, LEN_W_DEF=16.
  - The multiplier and future MAC blocks share this package.
- Single module; no sub-module needed. The beat counter and adder live inline.
- Adder is ACC_W+1 bits wide; the MSB is the carry into ovf.

## Test plan
- Basic dot product: start with len=3; products 6, 0xFFFF_FFFF, 1 on consecutive cycles; res_ready=1 → res_valid one cycle after third beat, res_data=0x1_0000_0006, res_ovf=0.
- Bubbles and backpressure: len=2; prod_valid gaps of 3 cycles; res_ready held low 5 cycles → no extra beats consumed, res_data stable at the sum throughout, single result transfer.
- Zero length: start with len=0 → res_valid in the following cycle, res_data=0, no product consumed even with prod_valid=1.
- Overflow with ACC_W=64: len=2; products 0xFFFF_FFFF_FFFF_FFFF and 2 → res_data=1, res_ovf=1. The next job (len=1, product 5) returns res_ovf=0 and res_data=5.
- Start while busy: assert start with len=7 during ACCUM and during DONE → ignored; original len=4 job completes with the correct sum.
- Mid-job reset: rst after 2 of 4 beats → following cycle all outputs at reset values. A new len=1 job then returns only its own product.
